// File: rtl/sccb_cmd_writer.sv
// SCCB write engine: pulls {register, value} commands from the OV2640 LUT and
// shifts each out as a 3-byte SCCB write until the 16'hFFFF end marker.
module sccb_cmd_writer #(
  parameter int         CLK_FREQ  = 27000000,
  parameter int         SCCB_FREQ = 100000,
  parameter logic [7:0] DEV_ADDR  = 8'h60,
  parameter int         PWRUP_CYC = 27000,
  parameter int         SRST_CYC  = 27000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        resend,
  output logic        advance,
  output logic        sioc,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);
  localparam int QDIV = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int CMAX = (PWRUP_CYC > SRST_CYC) ? PWRUP_CYC : SRST_CYC;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [QW-1:0] QLAST     = QW'(QDIV - 1);
  localparam logic [CW-1:0] PWR_LAST  = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] SRST_LAST = CW'(SRST_CYC - 1);
  localparam logic [15:0]   SRST_CMD  = 16'h1280;

  typedef enum logic [3:0] {
    S_PWRUP, S_FETCH, S_CHECK, S_START, S_BITS, S_STOP, S_GAP, S_SRST, S_DONE
  } state_t;

  state_t          state;
  logic [QW-1:0]   qcnt;
  logic [2:0]      q;      // quarter index within phase (0..7 in GAP)
  logic [3:0]      bi;     // slot within byte, 8 = don't-care slot
  logic [1:0]      by;     // byte index: addr, reg, value
  logic [CW-1:0]   cnt;
  logic [15:0]     shreg;
  logic            fin;
  logic            qtick;

  assign qtick = (qcnt == QLAST);

  // Bus levels {sioc, siod_oe} for the quarter about to begin, so the
  // registered pins line up exactly with the state they belong to.
  function automatic logic [1:0] bus_lvl(state_t st, logic [2:0] qq, logic [3:0] sb,
                                         logic [1:0] bb, logic [15:0] cmd);
    logic [7:0] b;
    b = (bb == 2'd0) ? DEV_ADDR : (bb == 2'd1) ? cmd[15:8] : cmd[7:0];
    bus_lvl = 2'b10;
    case (st)
      S_START: bus_lvl = {qq[1:0] != 2'd3, qq[1:0] != 2'd0};
      S_BITS:  bus_lvl = {qq[1], (sb != 4'd8) && !b[3'd7 - sb[2:0]]};
      S_STOP:  bus_lvl = {qq[1:0] != 2'd0, !qq[1]};
      default: ;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_PWRUP;
      qcnt    <= '0;
      q       <= '0;
      bi      <= '0;
      by      <= '0;
      cnt     <= '0;
      shreg   <= '0;
      fin     <= 1'b0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
      resend  <= 1'b0;
      advance <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      resend  <= 1'b0;
      advance <= 1'b0;
      if (state inside {S_START, S_BITS, S_STOP, S_GAP})
        qcnt <= qtick ? '0 : qcnt + 1'b1;
      case (state)
        S_PWRUP:
          if (cnt == PWR_LAST) begin
            cnt    <= '0;
            resend <= 1'b1;
            state  <= S_FETCH;
          end else cnt <= cnt + 1'b1;
        // LUT needs two edges after resend/advance before command is valid
        S_FETCH:
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            shreg <= command;
            fin   <= finished;
            state <= S_CHECK;
          end else cnt <= cnt + 1'b1;
        S_CHECK:
          if (fin) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_START;
            qcnt  <= '0;
            q     <= '0;
            {sioc, siod_oe} <= bus_lvl(S_START, 3'd0, 4'd0, 2'd0, shreg);
          end
        S_START:
          if (qtick) begin
            if (q == 3'd3) begin
              state <= S_BITS;
              q     <= '0;
              bi    <= '0;
              by    <= '0;
              {sioc, siod_oe} <= bus_lvl(S_BITS, 3'd0, 4'd0, 2'd0, shreg);
            end else begin
              q <= q + 3'd1;
              {sioc, siod_oe} <= bus_lvl(S_START, q + 3'd1, bi, by, shreg);
            end
          end
        S_BITS:
          if (qtick) begin
            if (q != 3'd3) begin
              q <= q + 3'd1;
              {sioc, siod_oe} <= bus_lvl(S_BITS, q + 3'd1, bi, by, shreg);
            end else begin
              q <= '0;
              if (bi != 4'd8) begin
                bi <= bi + 4'd1;
                {sioc, siod_oe} <= bus_lvl(S_BITS, 3'd0, bi + 4'd1, by, shreg);
              end else begin
                bi <= '0;
                if (by != 2'd2) begin
                  by <= by + 2'd1;
                  {sioc, siod_oe} <= bus_lvl(S_BITS, 3'd0, 4'd0, by + 2'd1, shreg);
                end else begin
                  state <= S_STOP;
                  {sioc, siod_oe} <= bus_lvl(S_STOP, 3'd0, 4'd0, 2'd0, shreg);
                end
              end
            end
          end
        S_STOP:
          if (qtick) begin
            if (q == 3'd3) begin
              state <= S_GAP;
              q     <= '0;
              {sioc, siod_oe} <= 2'b10;
            end else begin
              q <= q + 3'd1;
              {sioc, siod_oe} <= bus_lvl(S_STOP, q + 3'd1, bi, by, shreg);
            end
          end
        S_GAP:
          if (qtick) begin
            if (q == 3'd7) begin
              q   <= '0;
              cnt <= '0;
              if (shreg == SRST_CMD) state <= S_SRST;
              else begin
                advance <= 1'b1;
                state   <= S_FETCH;
              end
            end else q <= q + 3'd1;
          end
        S_SRST:
          if (cnt == SRST_LAST) begin
            cnt     <= '0;
            advance <= 1'b1;
            state   <= S_FETCH;
          end else cnt <= cnt + 1'b1;
        S_DONE:
          if (start) begin
            resend <= 1'b1;
            busy   <= 1'b1;
            done   <= 1'b0;
            cnt    <= '0;
            state  <= S_FETCH;
          end
        default: state <= S_PWRUP;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_cmd_writer.sv
// Bench for sccb_cmd_writer: registered LUT model, SCCB bus decoder and
// event timestamps compared against values derived from the protocol rules.
module tb_sccb_cmd_writer;
  localparam int         CLK_FREQ  = 2100000;
  localparam int         SCCB_FREQ = 100000;
  localparam int         QDIV      = CLK_FREQ / (4 * SCCB_FREQ);  // 5 (floor of 5.25)
  localparam int         PWRUP_CYC = 40;
  localparam int         SRST_CYC  = 100;
  localparam logic [7:0] DEV_ADDR  = 8'h60;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [15:0] command;
  logic finished;
  logic resend, advance, sioc, siod_oe, busy, done;

  logic [15:0] rom [0:15];
  logic [3:0]  lut_addr = 4'd0;
  int checks = 0, failures = 0;

  sccb_cmd_writer #(
    .CLK_FREQ(CLK_FREQ), .SCCB_FREQ(SCCB_FREQ), .DEV_ADDR(DEV_ADDR),
    .PWRUP_CYC(PWRUP_CYC), .SRST_CYC(SRST_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .command(command), .finished(finished),
    .resend(resend), .advance(advance), .sioc(sioc), .siod_oe(siod_oe),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // LUT: address register steps on the edge after the pulse, ROM read follows it
  always @(posedge clk)
    if (resend) lut_addr <= 4'd0;
    else if (advance) lut_addr <= lut_addr + 4'd1;
  assign command  = rom[lut_addr];
  assign finished = (command == 16'hFFFF);

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  // Bus decoder and event log
  logic p_sioc = 1'b1, p_oe = 1'b0, p_adv = 1'b0, p_res = 1'b0;
  bit in_frame = 0;
  int nbits = 0, last_rise = 0, bad = 0, edges = 0;
  logic [26:0] fbits = '0;
  logic [23:0] frames[$];
  int start_t[$], stop_t[$], adv_t[$], res_t[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_frame = 0;
      nbits = 0;
    end else begin
      if (siod_oe != p_oe && sioc) begin
        if (!p_sioc) bad++;
        else if (siod_oe) begin
          if (in_frame) bad++;
          in_frame = 1;
          nbits = 0;
          start_t.push_back(cyc);
        end else begin
          if (!in_frame || nbits != 27) bad++;
          else frames.push_back({fbits[26:19], fbits[17:10], fbits[8:1]});
          in_frame = 0;
          stop_t.push_back(cyc);
        end
      end
      if (sioc && !p_sioc && in_frame && nbits < 27) begin
        if (nbits % 9 == 8 && siod_oe) bad++;
        if (nbits > 0 && cyc - last_rise != 4 * QDIV) bad++;
        last_rise = cyc;
        fbits = {fbits[25:0], ~siod_oe};
        nbits++;
      end
      if (sioc != p_sioc) edges++;
      if (advance) adv_t.push_back(cyc);
      if (resend) res_t.push_back(cyc);
      if (advance && resend) bad++;
      if ((advance && p_adv) || (resend && p_res)) bad++;
    end
    p_sioc = sioc; p_oe = siod_oe; p_adv = advance; p_res = resend;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run time limit reached, required summary before limit");
    $fatal(1, "watchdog");
  end

  function automatic int n_writes();
    for (int k = 0; k < 16; k++) if (rom[k] == 16'hFFFF) return k;
    return 16;
  endfunction

  task automatic clear_mon();
    frames.delete(); start_t.delete(); stop_t.delete(); adv_t.delete(); res_t.delete();
    bad = 0; edges = 0;
  endtask

  task automatic rand_rom(input int lo, input int hi, input bit allow_srst);
    logic [15:0] v;
    int n;
    for (int k = 0; k < 16; k++) rom[k] = 16'hFFFF;
    n = $urandom_range(hi, lo);
    for (int k = 0; k < n; k++) begin
      v = 16'($urandom);
      if (allow_srst && $urandom_range(3, 0) == 0) v = 16'h1280;
      if (v == 16'hFFFF) v = 16'h0F0F;
      rom[k] = v;
    end
  endtask

  task automatic do_reset(output int t_rel);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    t_rel = cyc;
  endtask

  task automatic wait_done(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++; if (sioc !== 1'b1)    begin failures++; $display("FAIL reset_sioc: got %b, required 1", sioc); end
    checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL reset_siod_oe: got %b, required 0", siod_oe); end
    checks++; if (resend !== 1'b0)  begin failures++; $display("FAIL reset_resend: got %b, required 0", resend); end
    checks++; if (advance !== 1'b0) begin failures++; $display("FAIL reset_advance: got %b, required 0", advance); end
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL reset_busy: got %b, required 1", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
  endtask

  // Run 0 is the fixed power-up table; further runs use random tables.
  task automatic test_sequences();
    int t_rel, t_done, nw, exp_gap, r0;
    for (int run = 0; run < 4; run++) begin
      if (run == 0) begin
        for (int k = 0; k < 16; k++) rom[k] = 16'hFFFF;
        rom[0] = 16'hFF01; rom[1] = 16'h1280; rom[2] = 16'hFF00;
      end else rand_rom(1, 4, 1'b1);
      nw = n_writes();
      do_reset(t_rel);
      wait_done(20000, t_done);
      checks++;
      if (t_done < 0) begin failures++; $display("FAIL seq%0d_done: timeout, required done=1", run); end
      r0 = (res_t.size() > 0) ? res_t[0] : -1;
      checks++;
      if (res_t.size() != 1 || r0 != t_rel + PWRUP_CYC) begin
        failures++;
        $display("FAIL seq%0d_resend: got %0d pulses first at %0d, required 1 at %0d",
                 run, res_t.size(), r0, t_rel + PWRUP_CYC);
      end
      checks++;
      if (frames.size() != nw) begin
        failures++; $display("FAIL seq%0d_nwrites: got %0d, required %0d", run, frames.size(), nw);
      end
      for (int k = 0; k < nw && k < frames.size(); k++) begin
        checks++;
        if (frames[k] !== {DEV_ADDR, rom[k]}) begin
          failures++; $display("FAIL seq%0d_write%0d: got %h, required %h", run, k, frames[k], {DEV_ADDR, rom[k]});
        end
      end
      checks++;
      if (adv_t.size() != nw) begin
        failures++; $display("FAIL seq%0d_advances: got %0d, required %0d", run, adv_t.size(), nw);
      end
      for (int k = 0; k < nw && k < adv_t.size() && k < stop_t.size(); k++) begin
        exp_gap = 10 * QDIV + ((rom[k] == 16'h1280) ? SRST_CYC : 0);
        checks++;
        if (adv_t[k] - stop_t[k] != exp_gap) begin
          failures++; $display("FAIL seq%0d_gap%0d: got %0d cycles, required %0d", run, k, adv_t[k] - stop_t[k], exp_gap);
        end
      end
      if (start_t.size() > 0 && r0 >= 0) begin
        checks++;
        if (start_t[0] - r0 != 3 + QDIV) begin
          failures++; $display("FAIL seq%0d_first_start: got %0d, required %0d", run, start_t[0] - r0, 3 + QDIV);
        end
      end
      if (adv_t.size() > 0 && t_done >= 0) begin
        checks++;
        if (t_done - adv_t[adv_t.size()-1] != 3) begin
          failures++; $display("FAIL seq%0d_done_latency: got %0d, required 3", run, t_done - adv_t[adv_t.size()-1]);
        end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL seq%0d_protocol: got %0d violations, required 0", run, bad); end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL seq%0d_flags: got done=%b busy=%b, required done=1 busy=0", run, done, busy);
      end
    end
  endtask

  task automatic test_immediate_end();
    int t_rel, t_done, r0;
    for (int k = 0; k < 16; k++) rom[k] = 16'hFFFF;
    do_reset(t_rel);
    wait_done(PWRUP_CYC + 50, t_done);
    r0 = (res_t.size() > 0) ? res_t[0] : -1;
    checks++;
    if (t_done < 0 || t_done - r0 != 3) begin
      failures++; $display("FAIL imm_done_latency: got done at %0d resend at %0d, required 3 apart", t_done, r0);
    end
    checks++;
    if (adv_t.size() != 0) begin failures++; $display("FAIL imm_advances: got %0d, required 0", adv_t.size()); end
    checks++;
    if (edges != 0) begin failures++; $display("FAIL imm_sioc_toggles: got %0d, required 0", edges); end
  endtask

  task automatic test_restart();
    int t_done, nw, r0, guard;
    rand_rom(3, 4, 1'b0);
    nw = n_writes();
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (resend !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL restart_ack: got resend=%b busy=%b done=%b, required 1 1 0", resend, busy, done);
    end
    guard = 0;
    while (start_t.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
    repeat (20 * QDIV) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(20000, t_done);
    r0 = (res_t.size() > 0) ? res_t[0] : -1;
    checks++;
    if (res_t.size() != 1) begin failures++; $display("FAIL restart_resends: got %0d, required 1", res_t.size()); end
    checks++;
    if (start_t.size() == 0 || start_t[0] - r0 != 3 + QDIV) begin
      failures++; $display("FAIL restart_no_pwrup: got %0d starts, first %0d after resend, required %0d",
                           start_t.size(), (start_t.size() > 0) ? start_t[0] - r0 : -1, 3 + QDIV);
    end
    checks++;
    if (frames.size() != nw) begin failures++; $display("FAIL restart_nwrites: got %0d, required %0d", frames.size(), nw); end
    for (int k = 0; k < nw && k < frames.size(); k++) begin
      checks++;
      if (frames[k] !== {DEV_ADDR, rom[k]}) begin
        failures++; $display("FAIL restart_write%0d: got %h, required %h", k, frames[k], {DEV_ADDR, rom[k]});
      end
    end
    checks++;
    if (bad != 0 || t_done < 0) begin
      failures++; $display("FAIL restart_protocol: got %0d violations done_t=%0d, required 0 and done", bad, t_done);
    end
  endtask

  task automatic test_reset_mid();
    int t_rel, t_done, guard, r0;
    rand_rom(2, 2, 1'b0);
    do_reset(t_rel);
    guard = 0;
    while (start_t.size() == 0 && guard < PWRUP_CYC + 100) begin @(negedge clk); guard++; end
    repeat (51 * QDIV + 1) @(negedge clk);  // slot 12 (byte 2), first quarter
    checks++;
    if (sioc !== 1'b0 || frames.size() != 0) begin
      failures++; $display("FAIL mid_position: got sioc=%b frames=%0d, required sioc=0 frames=0", sioc, frames.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sioc !== 1'b1 || siod_oe !== 1'b0 || advance !== 1'b0) begin
      failures++; $display("FAIL mid_abort: got sioc=%b siod_oe=%b advance=%b, required 1 0 0", sioc, siod_oe, advance);
    end
    do_reset(t_rel);
    wait_done(20000, t_done);
    r0 = (res_t.size() > 0) ? res_t[0] : -1;
    checks++;
    if (r0 != t_rel + PWRUP_CYC) begin
      failures++; $display("FAIL mid_pwrup: got resend at %0d, required %0d", r0, t_rel + PWRUP_CYC);
    end
    checks++;
    if (frames.size() != 2 || frames[0] !== {DEV_ADDR, rom[0]}) begin
      failures++; $display("FAIL mid_replay: got %0d writes first %h, required 2 first %h",
                           frames.size(), (frames.size() > 0) ? frames[0] : 24'h0, {DEV_ADDR, rom[0]});
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 16'hFFFF;
    test_reset();
    test_sequences();
    test_immediate_end();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sccb_cmd_writer.md
Name: sccb_cmd_writer

Overview:
- Downstream consumer of the OV2640 register-command LUT.
- Fetches each 16-bit {register, value} command from the LUT via the resend/advance handshake.
- Serialises each command as a 3-phase SCCB write (device address, register, value) on sioc/siod.
- Stops and flags completion when the LUT presents the 16'hFFFF end marker.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- SCCB_FREQ, 100000, SCCB bit rate in Hz. Quarter-bit tick QDIV = CLK_FREQ/(4*SCCB_FREQ), integer floor (67 at defaults).
- DEV_ADDR, 8'h60, 8-bit SCCB write address.
- PWRUP_CYC, 27000, cycles to wait after reset release before the first fetch.
- SRST_CYC, 27000, cycles to wait after writing the soft-reset command 16'h1280.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; restarts the full sequence, accepted only in DONE.
- command  in  16  LUT output, [15:8] register, [7:0] value.
- finished  in  1  LUT end flag; high when command==16'hFFFF.
- resend  out  1  one-cycle pulse; resets the LUT address to 0.
- advance  out  1  one-cycle pulse; steps the LUT address by 1.
- sioc  out  1  SCCB clock, push-pull, idle 1.
- siod_oe  out  1  1 = drive siod low; 0 = release siod (pull-up gives 1).
- busy  out  1  high from sequence start until DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset values: sioc=1, siod_oe=0, resend=0, advance=0, busy=1, done=0. State=PWRUP, all counters 0. Reset mid-transfer aborts immediately, with no stop condition issued.
- Quarter-tick counter runs 0..QDIV-1 in START/BITS/STOP/GAP only, and resets to 0 on entry to each of those states.
- LUT latency: the address updates on the clock edge after resend/advance, and command updates one edge later. The block therefore samples command/finished exactly 2 cycles after the resend or advance pulse (FETCH, 2-cycle wait).
- PWRUP: count PWRUP_CYC cycles, then pulse resend for 1 cycle and go to FETCH.
- FETCH: wait 2 cycles, latch command into shreg, go to CHECK.
- CHECK:
  - finished=1: go to DONE.
  - finished=0: go to START.
- START, 4 quarters:
  - Q0 siod released, sioc=1.
  - Q1 siod low, sioc=1.
  - Q2 siod low, sioc=1.
  - Q3 sioc=0.
- BITS: 27 bit slots = 3 bytes of 9 slots, MSB first. Bytes are DEV_ADDR, shreg[15:8], shreg[7:0]. Slot 9 of each byte is the SCCB don't-care bit: siod released, ACK not sampled.
  - Each slot is 4 quarters: Q0 sioc=0 and siod set; Q1 sioc=0; Q2 sioc=1; Q3 sioc=1.
  - siod changes only while sioc=0.
- STOP, 4 quarters:
  - Q0 sioc=0, siod low.
  - Q1 sioc=1, siod low.
  - Q2 sioc=1, siod released.
  - Q3 sioc=1, siod released.
- GAP: 8 quarters idle, sioc=1 and siod released.
  - If the latched command==16'h1280, additionally wait SRST_CYC cycles.
  - Then pulse advance for 1 cycle and go to FETCH.
- DONE: done=1, busy=0, bus idle.
  - start=1: pulse resend, busy=1, done=0, go to FETCH. PWRUP is not repeated.
- start in any state other than DONE is ignored.
- resend and advance are never high in the same cycle, and each is high for exactly 1 cycle per event.
- Transaction length at defaults: (4+108+4)*67 = 7772 cycles from START entry to GAP entry.

Test Plan:
- Power-up, LUT model {0:16'hFF01, 1:16'h1280, 2:16'hFF00, 3:16'hFFFF} with 1-cycle registered latency -> after 27000 cycles one resend pulse. Decoded writes are 60 FF 01, then 60 12 80, then 60 FF 00. done=1 after the 3rd write, with exactly 3 advance pulses.
- Soft-reset gap -> time from STOP end of write 60 12 80 to the next advance equals 8*67+27000 cycles. Other writes take 8*67 cycles.
- Bit timing, defaults -> sioc period 268 cycles. Every siod transition occurs with sioc=0, except at start (siod falls with sioc=1) and at stop (siod rises with sioc=1). The 9th slot of each byte has siod_oe=0.
- Immediate end, LUT first entry 16'hFFFF -> no sioc toggling. done=1 exactly 3 cycles after the resend pulse, with zero advance pulses.
- Restart: start pulse in DONE -> resend pulse the next cycle, busy=1, and the full sequence is replayed without the PWRUP delay. A start pulse during BITS is ignored, with no change to the waveform.
- Reset mid-transfer: rst_n low during byte 2 -> same cycle gives sioc=1, siod_oe=0, advance=0. After release the block repeats PWRUP and starts again from LUT entry 0.
